// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the bus, decodes 11-bit frames,
// and assembles multi-byte scancode sequences into single key events.
module ps2_key_event_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [64:0] ps2_key,
  output logic        frame_err,
  output logic        busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // index 0 = clock line, index 1 = data line
  logic [1:0] line_raw;
  logic [1:0] meta_reg;
  logic [1:0] sync_reg;

  assign line_raw = {ps2_data, ps2_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk_sys) begin
        if (reset) begin
          meta_reg[gi] <= 1'b1;
          sync_reg[gi] <= 1'b1;
        end else begin
          meta_reg[gi] <= line_raw[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  logic          clk_filt_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          fall;
  logic          data_bit;

  assign data_bit = sync_reg[1];
  // The falling edge is the very cycle the filtered level flips from 1 to 0.
  assign fall = clk_filt_reg && !sync_reg[0] && (filt_cnt_reg == FW'(FILTER_LEN - 1));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_filt_reg <= 1'b1;
      filt_cnt_reg <= '0;
    end else if (sync_reg[0] != clk_filt_reg) begin
      if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
        clk_filt_reg <= sync_reg[0];
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + FW'(1);
      end
    end else begin
      filt_cnt_reg <= '0;
    end
  end

  state_t        state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic [TW-1:0] to_cnt_reg;
  logic          timeout;
  logic          err_next;
  logic          byte_good;

  assign busy    = (state_reg != IDLE);
  assign timeout = busy && (to_cnt_reg == TW'(TIMEOUT));

  always_ff @(posedge clk_sys) begin
    if (reset || fall || !busy) begin
      to_cnt_reg <= '0;
    end else if (to_cnt_reg != TW'(TIMEOUT)) begin
      to_cnt_reg <= to_cnt_reg + TW'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    err_next     = 1'b0;
    byte_good    = 1'b0;
    if (timeout) begin
      state_next = IDLE;
      err_next   = 1'b1;
    end else if (fall) begin
      case (state_reg)
        IDLE: begin
          if (!data_bit) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end
        end
        DATA: begin
          shift_next = {data_bit, shift_reg[7:1]};
          if (bit_cnt_reg == 3'd7) state_next = PARITY;
          else bit_cnt_next = bit_cnt_reg + 3'd1;
        end
        PARITY: begin
          if (^{shift_reg, data_bit}) begin
            state_next = STOP;
          end else begin
            state_next = IDLE;
            err_next   = 1'b1;
          end
        end
        STOP: begin
          state_next = IDLE;
          if (data_bit) byte_good = 1'b1;
          else err_next = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  logic [63:0] seq_reg;
  logic [3:0]  byte_cnt_reg;
  logic        e1_mode_reg;
  logic        complete_pending_reg;
  logic        frame_err_reg;
  logic [64:0] key_reg;
  logic        starts_e1;
  logic        completes;

  assign starts_e1 = (byte_cnt_reg == 4'd0) && (shift_reg == 8'hE1);

  // Decide whether the byte being shifted in closes the current sequence.
  always_comb begin
    completes = 1'b1;
    if (e1_mode_reg) begin
      completes = (byte_cnt_reg == 4'd7);
    end else if (starts_e1 || shift_reg == 8'hE0 || shift_reg == 8'hF0) begin
      completes = 1'b0;
    end else if (seq_reg[7:0] == 8'hE0 && shift_reg == 8'h12) begin
      completes = 1'b0;
    end else if (seq_reg[15:0] == 16'hE0F0 && shift_reg == 8'h7C) begin
      completes = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      seq_reg              <= '0;
      byte_cnt_reg         <= '0;
      e1_mode_reg          <= 1'b0;
      complete_pending_reg <= 1'b0;
      frame_err_reg        <= 1'b0;
      key_reg              <= '0;
    end else begin
      frame_err_reg        <= err_next;
      complete_pending_reg <= 1'b0;
      if (complete_pending_reg) begin
        key_reg      <= {~key_reg[64], seq_reg};
        seq_reg      <= '0;
        byte_cnt_reg <= '0;
        e1_mode_reg  <= 1'b0;
      end
      if (err_next) begin
        seq_reg      <= '0;
        byte_cnt_reg <= '0;
        e1_mode_reg  <= 1'b0;
      end else if (byte_good) begin
        seq_reg              <= {seq_reg[55:0], shift_reg};
        byte_cnt_reg         <= (byte_cnt_reg == 4'hF) ? byte_cnt_reg : byte_cnt_reg + 4'd1;
        e1_mode_reg          <= e1_mode_reg | starts_e1;
        complete_pending_reg <= completes;
      end
    end
  end

  assign ps2_key   = key_reg;
  assign frame_err = frame_err_reg;

endmodule
